// File: rtl/dac8563_setpoint_ramp_pkg.sv
// Purpose: shared types, constants and ramp arithmetic for the DAC8563 setpoint feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dac8563_setpoint_ramp_pkg;

    localparam int   DAC_W = 16;
    localparam logic CH_A  = 1'b0;
    localparam logic CH_B  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_WAIT_A,
        ST_LOAD_B,
        ST_WAIT_B
    } state_t;

    // One slew step of cur toward tgt. The difference is taken in 17-bit signed
    // so the full 0x0000..0xFFFF span is representable. Moving by step is only
    // done when |diff| > step, so the result can never overshoot or wrap.
    function automatic logic [DAC_W-1:0] ramp_next(input logic [DAC_W-1:0] cur,
                                                   input logic [DAC_W-1:0] tgt,
                                                   input logic [DAC_W-1:0] step);
        logic signed [DAC_W:0] diff;
        logic        [DAC_W:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DAC_W] ? -diff : diff;
        if (step == '0 || mag <= {1'b0, step}) begin
            ramp_next = tgt;
        end else if (!diff[DAC_W]) begin
            ramp_next = cur + step;
        end else begin
            ramp_next = cur - step;
        end
    endfunction

endpackage

// File: rtl/dac8563_setpoint_ramp_tick_gen.sv
// Purpose: free-running divider producing the ramp tick (one pulse every TICK_DIV cycles).
// Latency: tick is combinational from the counter, high in the cycle count == TICK_DIV-1.
// Backpressure: none; free-running, the consumer must coalesce ticks it cannot take.
// Ports: clk, rst_n (async active-low), tick (1-cycle pulse at counter wrap).
module dac8563_setpoint_ramp_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac8563_setpoint_ramp.sv
// Purpose: latches A/B setpoints and slews both DAC codes toward them, feeding the
//          serializer one word at a time (A then B, always as a pair).
// Latency: tick -> data_valid is 2 cycles (ramp compute, LOAD_A); words held until dac_done.
// Backpressure: waits on dac_done per word; ticks during a busy pair coalesce into one
//               pending update; a missing dac_done times out, sets err and retries the pair.
// Ports: sys_clk, rst_n | tgt_a, tgt_b, tgt_load (setpoint strobe) | dac_done (serializer ack)
//        | data, data_sel, data_valid (word to serializer) | at_target, err (status).
module dac8563_setpoint_ramp
    import dac8563_setpoint_ramp_pkg::*;
#(
    parameter int               TICK_DIV  = 1000,
    parameter logic [DAC_W-1:0] STEP      = 16'd64,
    parameter logic [DAC_W-1:0] INIT_CODE = 16'h0000,
    parameter int               TIMEOUT   = 4096
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [DAC_W-1:0] tgt_a,
    input  logic [DAC_W-1:0] tgt_b,
    input  logic             tgt_load,
    input  logic             dac_done,
    output logic [DAC_W-1:0] data,
    output logic             data_sel,
    output logic             data_valid,
    output logic             at_target,
    output logic             err
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_t           state, state_n;
    logic [DAC_W-1:0] cur_a, cur_a_n, cur_b, cur_b_n;
    logic [DAC_W-1:0] tgt_a_q, tgt_a_n, tgt_b_q, tgt_b_n;
    logic [DAC_W-1:0] ramp_a, ramp_b;
    logic [DAC_W-1:0] data_n;
    logic             data_sel_n, data_valid_n, at_target_n, err_n;
    logic             force_wr, force_wr_n;
    logic             pending, pending_n;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
    logic             tick;

    dac8563_setpoint_ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_a      <= INIT_CODE;
            cur_b      <= INIT_CODE;
            tgt_a_q    <= INIT_CODE;
            tgt_b_q    <= INIT_CODE;
            data       <= INIT_CODE;
            data_sel   <= CH_A;
            data_valid <= 1'b0;
            at_target  <= 1'b0;
            err        <= 1'b0;
            force_wr   <= 1'b1;
            pending    <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            state      <= state_n;
            cur_a      <= cur_a_n;
            cur_b      <= cur_b_n;
            tgt_a_q    <= tgt_a_n;
            tgt_b_q    <= tgt_b_n;
            data       <= data_n;
            data_sel   <= data_sel_n;
            data_valid <= data_valid_n;
            at_target  <= at_target_n;
            err        <= err_n;
            force_wr   <= force_wr_n;
            pending    <= pending_n;
            wd_cnt     <= wd_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        cur_a_n      = cur_a;
        cur_b_n      = cur_b;
        tgt_a_n      = tgt_a_q;
        tgt_b_n      = tgt_b_q;
        data_n       = data;
        data_sel_n   = data_sel;
        data_valid_n = data_valid;
        err_n        = err;
        force_wr_n   = force_wr;
        pending_n    = pending;
        wd_cnt_n     = wd_cnt;

        // The ramp reads the registered targets, so a tick coinciding with
        // tgt_load still slews toward the old setpoint.
        ramp_a = ramp_next(cur_a, tgt_a_q, STEP);
        ramp_b = ramp_next(cur_b, tgt_b_q, STEP);

        if (tgt_load) begin
            tgt_a_n = tgt_a;
            tgt_b_n = tgt_b;
        end

        if (tick && state != ST_IDLE) begin
            pending_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                // cur codes only move here, so each pair is a coherent snapshot.
                if (tick || pending) begin
                    pending_n = 1'b0;
                    cur_a_n   = ramp_a;
                    cur_b_n   = ramp_b;
                    if (ramp_a != cur_a || ramp_b != cur_b || force_wr) begin
                        force_wr_n = 1'b0;
                        state_n    = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                data_n       = (state == ST_LOAD_A) ? cur_a : cur_b;
                data_sel_n   = (state == ST_LOAD_A) ? CH_A : CH_B;
                data_valid_n = 1'b1;
                wd_cnt_n     = '0;
                state_n      = (state == ST_LOAD_A) ? ST_WAIT_A : ST_WAIT_B;
            end
            ST_WAIT_A, ST_WAIT_B: begin
                if (dac_done) begin
                    data_valid_n = 1'b0;
                    state_n      = (state == ST_WAIT_A) ? ST_LOAD_B : ST_IDLE;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    // data_valid has now been high for TIMEOUT cycles.
                    err_n        = 1'b1;
                    data_valid_n = 1'b0;
                    force_wr_n   = 1'b1;
                    state_n      = ST_IDLE;
                end else begin
                    wd_cnt_n = wd_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        at_target_n = (state_n == ST_IDLE) && (cur_a_n == tgt_a_n) && (cur_b_n == tgt_b_n);
    end

endmodule

// File: tb/tb_dac8563_setpoint_ramp.sv
// Purpose: directed self-checking bench for dac8563_setpoint_ramp with a serializer model.
// Latency: serializer model acks each word done_dly cycles after data_valid rises.
// Backpressure: done_en=0 withholds the ack to exercise the timeout path.
module tb_dac8563_setpoint_ramp;

    logic        sys_clk;
    logic        rst_n;
    logic [15:0] tgt_a, tgt_b;
    logic        tgt_load;
    logic        dac_done;
    logic [15:0] data;
    logic        data_sel, data_valid, at_target, err;

    int checks   = 0;
    int failures = 0;

    // serializer model state
    int          cyc      = 0;
    int          done_dly = 40;
    bit          done_en  = 1'b1;
    bit          rsp_active = 1'b0;
    int          rsp_cnt  = 0;
    int          last_len = 0;
    int          unstable = 0;
    logic [16:0] cur_word;
    logic [16:0] wq[$];
    int          rq[$];
    int          rel;
    int          k;

    dac8563_setpoint_ramp #(
        .TICK_DIV  (4),
        .STEP      (16'd64),
        .INIT_CODE (16'h0000),
        .TIMEOUT   (64)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .tgt_a      (tgt_a),
        .tgt_b      (tgt_b),
        .tgt_load   (tgt_load),
        .dac_done   (dac_done),
        .data       (data),
        .data_sel   (data_sel),
        .data_valid (data_valid),
        .at_target  (at_target),
        .err        (err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Serializer model: logs each word {sel,data} and its rise cycle, checks the
    // word stays constant while valid, acks after done_dly valid-high cycles.
    initial begin
        dac_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            dac_done = 1'b0;
            if (data_valid) begin
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    rsp_cnt    = 0;
                    cur_word   = {data_sel, data};
                    wq.push_back(cur_word);
                    rq.push_back(cyc);
                end else if ({data_sel, data} !== cur_word) begin
                    unstable++;
                end
                rsp_cnt++;
                if (done_en && rsp_cnt == done_dly) dac_done = 1'b1;
            end else if (rsp_active) begin
                rsp_active = 1'b0;
                last_len   = rsp_cnt;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        tgt_a    = a;
        tgt_b    = b;
        tgt_load = 1'b1;
        step(1);
        tgt_load = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (wq.size() < n && i < budget) begin
            step(1);
            i++;
        end
        chk(tag, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic clear_log();
        wq.delete();
        rq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"},      32'(data),       32'h0000);
        chk({tag, "_sel"},       32'(data_sel),   32'd0);
        chk({tag, "_valid"},     32'(data_valid), 32'd0);
        chk({tag, "_at_target"}, 32'(at_target),  32'd0);
        chk({tag, "_err"},       32'(err),        32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        tgt_a    = 16'h0000;
        tgt_b    = 16'h0000;
        tgt_load = 1'b0;

        // 1: reset values, forced INIT pair, tick -> valid latency
        step(3);
        check_reset_outputs("rst");
        @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        rel   = cyc;
        wait_words(2, 400, "t1_wait");
        // tick after edge 3 (count==3), LOAD_A at edge 4, valid at edge 5 -> 6th negedge
        chk("t1_latency", 32'(rq[0] - rel), 32'd6);
        chk("t1_word_a", 32'(wq[0]), {15'd0, 1'b0, 16'h0000});
        chk("t1_word_b", 32'(wq[1]), {15'd0, 1'b1, 16'h0000});
        step(60);
        chk("t1_at_target", 32'(at_target), 32'd1);
        chk("t1_idle_valid", 32'(data_valid), 32'd0);
        chk("t1_no_extra", 32'(wq.size()), 32'd2);

        // 2: ramp A up by STEP per update, B rewritten each pair
        clear_log();
        load(16'h0100, 16'h0000);
        chk("t2_at_target_drop", 32'(at_target), 32'd0);
        wait_words(8, 1500, "t2_wait");
        chk("t2_a0", 32'(wq[0]), {15'd0, 1'b0, 16'h0040});
        chk("t2_a1", 32'(wq[2]), {15'd0, 1'b0, 16'h0080});
        chk("t2_a2", 32'(wq[4]), {15'd0, 1'b0, 16'h00C0});
        chk("t2_a3", 32'(wq[6]), {15'd0, 1'b0, 16'h0100});
        for (int i = 1; i < 8; i += 2) chk("t2_b", 32'(wq[i]), {15'd0, 1'b1, 16'h0000});
        step(100);
        chk("t2_no_extra", 32'(wq.size()), 32'd8);
        chk("t2_at_target", 32'(at_target), 32'd1);

        // 4: withheld ack -> timeout after TIMEOUT valid cycles, sticky err, pair retried
        clear_log();
        last_len = 0;
        done_en  = 1'b0;
        load(16'h0100, 16'h0010);
        k = 0;
        while (last_len == 0 && k < 300) begin
            step(1);
            k++;
        end
        done_en = 1'b1;
        chk("t4_valid_len", 32'(last_len), 32'd64);
        chk("t4_err", 32'(err), 32'd1);
        wait_words(3, 400, "t4_wait");
        chk("t4_timed_out_a", 32'(wq[0]), {15'd0, 1'b0, 16'h0100});
        chk("t4_retry_a", 32'(wq[1]), {15'd0, 1'b0, 16'h0100});
        chk("t4_retry_b", 32'(wq[2]), {15'd0, 1'b1, 16'h0010});
        step(100);
        chk("t4_err_sticky", 32'(err), 32'd1);
        chk("t4_at_target", 32'(at_target), 32'd1);
        chk("t4_no_extra", 32'(wq.size()), 32'd3);

        // 5: slow ack with fast ticks -> one step per pair, back-to-back pairs
        clear_log();
        done_dly = 20;
        load(16'h0020, 16'h0010);
        wait_words(8, 800, "t5_wait");
        chk("t5_a0", 32'(wq[0]), {15'd0, 1'b0, 16'h00C0});
        chk("t5_a1", 32'(wq[2]), {15'd0, 1'b0, 16'h0080});
        chk("t5_a2", 32'(wq[4]), {15'd0, 1'b0, 16'h0040});
        chk("t5_a3_partial", 32'(wq[6]), {15'd0, 1'b0, 16'h0020});
        chk("t5_b3", 32'(wq[7]), {15'd0, 1'b1, 16'h0010});
        // A ack at rise+19 -> LOAD_B gap -> B rise at A rise+21
        chk("t5_a_to_b", 32'(rq[1] - rq[0]), 32'd21);
        // B ack -> IDLE consumes pending -> LOAD_A -> next A rise at B rise+22
        chk("t5_b_to_a", 32'(rq[2] - rq[1]), 32'd22);
        step(100);
        chk("t5_no_extra", 32'(wq.size()), 32'd8);

        // 3a: ramp down 0x0020 -> 0x0000 without wrapping
        clear_log();
        load(16'h0000, 16'h0010);
        wait_words(2, 200, "t3d_wait");
        chk("t3_down_zero", 32'(wq[0]), {15'd0, 1'b0, 16'h0000});
        step(60);
        chk("t3_down_no_extra", 32'(wq.size()), 32'd2);

        // 3b: long ramp to 0xFFC0 (1023 steps), then clamp to 0xFFFF
        clear_log();
        done_dly = 2;
        load(16'hFFC0, 16'h0010);
        wait_words(2046, 20000, "t3u_wait");
        chk("t3_up_first", 32'(wq[0]), {15'd0, 1'b0, 16'h0040});
        chk("t3_up_last", 32'(wq[2044]), {15'd0, 1'b0, 16'hFFC0});
        chk("t3_up_last_b", 32'(wq[2045]), {15'd0, 1'b1, 16'h0010});
        step(30);
        chk("t3_up_no_extra", 32'(wq.size()), 32'd2046);
        clear_log();
        load(16'hFFFF, 16'h0010);
        wait_words(2, 100, "t3c_wait");
        chk("t3_clamp_ffff", 32'(wq[0]), {15'd0, 1'b0, 16'hFFFF});
        step(20);
        chk("t3_clamp_at_target", 32'(at_target), 32'd1);

        // 6: reset asserted during WAIT_B -> outputs back to reset immediately, INIT pair again
        clear_log();
        done_dly = 40;
        load(16'hFFFF, 16'h0020);
        k = 0;
        while (!(data_valid && data_sel) && k < 300) begin
            step(1);
            k++;
        end
        chk("t6_in_wait_b", 32'(data_valid && data_sel), 32'd1);
        chk("t6_b_word", 32'(data), 32'h0020);
        @(posedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        step(3);
        clear_log();
        @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        rel   = cyc;
        wait_words(2, 400, "t6_wait");
        chk("t6_latency", 32'(rq[0] - rel), 32'd6);
        chk("t6_init_a", 32'(wq[0]), {15'd0, 1'b0, 16'h0000});
        chk("t6_init_b", 32'(wq[1]), {15'd0, 1'b1, 16'h0000});
        step(5);

        chk("data_stable", 32'(unstable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
